// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//
// Drain stage between a single-clock byte FIFO and a UART pin. Pops one byte
// at a time through the FIFO read port and serialises it 8N1 (start, 8 data
// bits LSB first, stop) at CLKS_PER_BIT clocks per bit. Reports a busy flag
// and a wrapping count of completed frames.
//
// Optional feature: define FIFO_UART_TX_PARITY_EN to insert an even-parity
// bit between the last data bit and the stop bit (frame becomes 8E1).
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit (2..65535)
//   COUNT_W       width of frame_count
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   tx_enable    in   permits fetching of new bytes
//   buf_empty    in   FIFO empty flag
//   buf_out      in   FIFO read data, valid the cycle after rd_en is sampled
//   rd_en        out  FIFO pop strobe, one-cycle pulse per byte (registered)
//   tx           out  serial line, idle high (registered)
//   tx_busy      out  high from the rd_en cycle through the last stop cycle
//   frame_count  out  frames completed since reset, wraps
//   dbg_state_o  out  current FSM state encoding (observation only)
//
// FIFO read handshake: the FIFO offers data when buf_empty=0 (its "valid");
// rd_en is this block's one-cycle "ready/take". A pop is only issued when
// tx_enable=1 and buf_empty=0 are both sampled on the deciding clock edge,
// and no further pop is issued until the fetched byte has been fully sent,
// so at most one pop is ever outstanding. The popped byte is captured one
// cycle after the rd_en cycle.
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int COUNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tx_enable,
  input  logic               buf_empty,
  input  logic [7:0]         buf_out,
  output logic               rd_en,
  output logic               tx,
  output logic               tx_busy,
  output logic [COUNT_W-1:0] frame_count,
  output logic [2:0]         dbg_state_o
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic                 rd_en_q, rd_en_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 baud_last;
  logic                 can_fetch;

  assign baud_last = (baud_q == BAUD_LAST);
  assign can_fetch = tx_enable && !buf_empty;

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    count_d = count_q;
    rd_en_d = 1'b0;

    case (state_q)
      // The rd_en pulse is visible while the FSM sits in IDLE. Arriving from
      // a completed frame it was already decided on the last stop edge, so the
      // very first IDLE cycle carries it; otherwise IDLE samples the FIFO and
      // raises rd_en for the following cycle. Once rd_en is high, move on.
      ST_IDLE: begin
        if (rd_en_q) begin
          state_d = ST_FETCH;
        end else if (can_fetch) begin
          rd_en_d = 1'b1;
        end
      end

      // buf_out now holds the byte popped by the previous rd_en cycle.
      ST_FETCH: begin
        shift_d = buf_out;
        baud_d  = '0;
        state_d = ST_START;
      end

      ST_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      ST_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      ST_PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = ST_STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      ST_STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          count_d = count_q + COUNT_W'(1);
          state_d = ST_IDLE;
          // Deciding the next pop here lets the first IDLE cycle carry rd_en,
          // giving back-to-back frames a 2-cycle gap (IDLE + FETCH).
          if (can_fetch) begin
            rd_en_d = 1'b1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // tx is registered: it reflects the level belonging to the state being
    // entered, so it changes on the same edge as the state.
    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[bit_d];
      ST_PARITY: tx_d = ^shift_d;
      default:   tx_d = 1'b1;
    endcase

    busy_d = rd_en_d || (state_d != ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      rd_en_q <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      rd_en_q <= rd_en_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign rd_en       = rd_en_q;
  assign tx          = tx_q;
  assign tx_busy     = busy_q;
  assign frame_count = count_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
//
// Directed bench for fifo_uart_tx with CLKS_PER_BIT=4. A small queue models
// the FIFO read port; a line decoder turns tx back into bytes. A table of
// bytes with hand-written line levels is checked cycle by cycle, followed by
// hand-written sequences for back-to-back frames, tx_enable gating and reset
// in the middle of a frame.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

  localparam int N = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int LAST   = 1 + FB * N;  // offset of last stop cycle from rd_en
  localparam int PERIOD = 2 + FB * N;

  // ---------------------------------------------------------------- clock/reset
  logic        clk = 1'b0;
  logic        rst;
  logic        tx_enable;
  logic        buf_empty = 1'b1;
  logic [7:0]  buf_out = 8'h00;
  logic        rd_en;
  logic        tx;
  logic        tx_busy;
  logic [15:0] frame_count;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(N), .COUNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_enable   (tx_enable),
    .buf_empty   (buf_empty),
    .buf_out     (buf_out),
    .rd_en       (rd_en),
    .tx          (tx),
    .tx_busy     (tx_busy),
    .frame_count (frame_count),
    .dbg_state_o (dbg_state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- FIFO model
  logic [7:0] fifo_q[$];
  int         pop_err = 0;

  always @(posedge clk) begin
    if (rd_en) begin
      if (fifo_q.size() == 0) pop_err <= pop_err + 1;
      else buf_out <= fifo_q.pop_front();
    end
  end

  always @(negedge clk) buf_empty <= (fifo_q.size() == 0);

  // ---------------------------------------------------------------- monitor
  int         cyc = 0;
  int         rd_log[$];
  logic [7:0] rx_q[$];
  logic       dec_active = 1'b0;
  int         dec_t = 0;
  logic [7:0] dec_byte = 8'h00;
  int         frame_err = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) rd_log.push_back(cyc);
    if (rst) begin
      dec_active <= 1'b0;
    end else if (!dec_active) begin
      if (!tx) begin
        dec_active <= 1'b1;
        dec_t      <= 1;
      end
    end else begin
      if (dec_t >= N + N / 2 && dec_t <= 8 * N + N / 2 && ((dec_t - N / 2) % N) == 0)
        dec_byte <= {tx, dec_byte[7:1]};
      if (dec_t == (FB - 1) * N + N / 2) begin
        dec_active <= 1'b0;
        if (tx) rx_q.push_back(dec_byte);
        else frame_err <= frame_err + 1;
      end
      dec_t <= dec_t + 1;
    end
  end

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_rd(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rd_en) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got no rd_en within %0d cycles expected rd_en", name, budget);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic [7:0] data;
    logic [9:0] levels;  // bit0 = start, bits 8:1 = data LSB first, bit9 = stop
    logic       par;     // even parity of data
  } vec_t;

  vec_t        vecs[7];
  logic [15:0] exp_count;

  initial begin
    vecs[0] = '{8'hA5, 10'b1_10100101_0, 1'b0};
    vecs[1] = '{8'h01, 10'b1_00000001_0, 1'b1};
    vecs[2] = '{8'h80, 10'b1_10000000_0, 1'b1};
    vecs[3] = '{8'hFF, 10'b1_11111111_0, 1'b0};
    vecs[4] = '{8'h00, 10'b1_00000000_0, 1'b0};
    vecs[5] = '{8'h07, 10'b1_00000111_0, 1'b1};
    vecs[6] = '{8'h03, 10'b1_00000011_0, 1'b0};

    // Reset with a non-empty FIFO and fetching allowed.
    rst       = 1'b1;
    tx_enable = 1'b1;
    exp_count = 16'd0;
    push(vecs[0].data);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_tx", tx, 1'b1);
      check("reset_rd_en", rd_en, 1'b0);
      check("reset_busy", tx_busy, 1'b0);
      check("reset_count", frame_count, 16'd0);
      check("reset_state", dbg_state, 3'd0);
    end
    rst = 1'b0;

    // Table: one byte at a time, every cycle of the frame checked.
    for (int v = 0; v < 7; v++) begin
      logic etx;
      int   idx;
      if (v != 0) push(vecs[v].data);
      wait_rd($sformatf("vec%0d_rd_en", v), 20);
      for (int off = 0; off <= LAST + 1; off++) begin
        if (off != 0) @(negedge clk);
        if (off < 2 || off > LAST) etx = 1'b1;
        else begin
          idx = (off - 2) / N;
          if (FB == 11 && idx == 9) etx = vecs[v].par;
          else if (FB == 11 && idx == 10) etx = 1'b1;
          else etx = vecs[v].levels[idx];
        end
        check($sformatf("vec%0d_tx_off%0d", v, off), tx, etx);
        check($sformatf("vec%0d_rd_en_off%0d", v, off), rd_en, (off == 0));
        check($sformatf("vec%0d_busy_off%0d", v, off), tx_busy, (off <= LAST));
        if (off == LAST) check($sformatf("vec%0d_count_pre", v), frame_count, exp_count);
        if (off == LAST + 1) check($sformatf("vec%0d_count_post", v), frame_count, exp_count + 16'd1);
      end
      exp_count = exp_count + 16'd1;
    end

    // Three bytes queued together: back-to-back frames.
    rd_log.delete();
    rx_q.delete();
    push(8'h01);
    push(8'h80);
    push(8'hFF);
    wait_rd("b2b_first_rd_en", 20);
    repeat (3 * PERIOD + 5) @(negedge clk);
    exp_count = exp_count + 16'd3;
    check("b2b_rd_count", rd_log.size(), 3);
    if (rd_log.size() == 3) begin
      check("b2b_gap01", rd_log[1] - rd_log[0], PERIOD);
      check("b2b_gap12", rd_log[2] - rd_log[1], PERIOD);
    end
    check("b2b_rx_count", rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      check("b2b_rx0", rx_q[0], 8'h01);
      check("b2b_rx1", rx_q[1], 8'h80);
      check("b2b_rx2", rx_q[2], 8'hFF);
    end
    check("b2b_count", frame_count, exp_count);
    check("b2b_busy", tx_busy, 1'b0);
    check("b2b_tx_idle", tx, 1'b1);

    // tx_enable low holds off fetching; dropped mid-frame lets it finish.
    @(negedge clk);
    tx_enable = 1'b0;
    rd_log.delete();
    rx_q.delete();
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    push(8'h55);
    repeat (200) @(negedge clk);
    check("gate_no_rd_en", rd_log.size(), 0);
    check("gate_busy", tx_busy, 1'b0);
    tx_enable = 1'b1;
    wait_rd("gate_rd_en", 10);
    repeat (6) @(negedge clk);  // first data bit
    tx_enable = 1'b0;
    repeat (100) @(negedge clk);
    exp_count = exp_count + 16'd1;
    check("gate_rd_count", rd_log.size(), 1);
    check("gate_rx_count", rx_q.size(), 1);
    if (rx_q.size() == 1) check("gate_rx0", rx_q[0], 8'h11);
    check("gate_count", frame_count, exp_count);
    check("gate_busy_end", tx_busy, 1'b0);

    // Reset during data bit 3 of 8'h3C.
    fifo_q.delete();
    @(negedge clk);
    @(negedge clk);
    push(8'h3C);
    push(8'h5A);
    rd_log.delete();
    rx_q.delete();
    tx_enable = 1'b1;
    wait_rd("rst_rd_en", 10);
    repeat (19) @(negedge clk);  // bit 3 spans offsets 18..21
    check("rst_pre_busy", tx_busy, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_async_tx", tx, 1'b1);
    check("rst_async_busy", tx_busy, 1'b0);
    check("rst_async_rd_en", rd_en, 1'b0);
    check("rst_async_count", frame_count, 16'd0);
    check("rst_async_state", dbg_state, 3'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_hold_tx", tx, 1'b1);
      check("rst_hold_rd_en", rd_en, 1'b0);
    end
    rst = 1'b0;
    exp_count = 16'd0;
    rd_log.delete();
    rx_q.delete();
    wait_rd("rst_next_rd_en", 10);
    repeat (LAST + 1) @(negedge clk);
    exp_count = exp_count + 16'd1;
    check("rst_rx_count", rx_q.size(), 1);
    if (rx_q.size() == 1) check("rst_rx0", rx_q[0], 8'h5A);
    check("rst_count", frame_count, exp_count);
    check("rst_busy_end", tx_busy, 1'b0);

    repeat (5) @(negedge clk);
    check("fifo_pop_while_empty", pop_err, 0);
    check("framing_errors", frame_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Downstream drain stage for the single-clock byte FIFO. It pops bytes through the FIFO read port (rd_en / buf_out / buf_empty) and serializes each one onto a UART line, 8N1, LSB first, at a programmable baud divisor. It sits between the FIFO and the board pin, and also reports a busy flag and a running frame count.

## Interface
- CLKS_PER_BIT, 16, clk cycles per UART bit; legal range 2..65535
- COUNT_W, 16, width of frame_count
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- tx_enable  input  1  when 1, fetching of new bytes is permitted
- buf_empty  input  1  FIFO empty flag
- buf_out  input  8  FIFO read data; valid the cycle after rd_en is sampled high
- rd_en  output  1  FIFO pop strobe; single-cycle pulse per byte
- tx  output  1  serial line; idle high
- tx_busy  output  1  1 from rd_en pulse through last stop-bit cycle
- frame_count  output  COUNT_W  frames completed since reset

## Operation
- States:
  - IDLE: tx=1. If tx_enable && !buf_empty, assert rd_en for this cycle and go to FETCH; else stay.
  - FETCH: latch buf_out into the shift register; go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, bit 0 first, CLKS_PER_BIT cycles each.
  - PARITY: only when the macro is defined.
  - STOP: tx=1 for CLKS_PER_BIT cycles; on its last cycle frame_count increments; go to IDLE.
- Counters:
  - Baud counter counts 0..CLKS_PER_BIT-1 and reloads at each bit boundary.
  - Bit index counts 0..7.
- rd_en is asserted only in IDLE, so at most one pop is outstanding. rd_en is never asserted while buf_empty=1.
- tx_enable dropping mid-frame: the current frame completes unchanged; no further rd_en until tx_enable returns.
- buf_empty changing during a frame has no effect until the next IDLE cycle.
- frame_count wraps from 2^COUNT_W-1 to 0.
- tx, rd_en and tx_busy are registered outputs. No combinational path from inputs to outputs.

## Timing
- Reset values: tx=1, rd_en=0, tx_busy=0, frame_count=0, state=IDLE, shift register=0.
- Reset asserted mid-frame:
  - tx returns to 1 asynchronously and the in-flight byte is discarded; the FIFO is not rewound.
  - After reset deasserts, the first rd_en comes no earlier than the first IDLE clock edge.
- Latency: with the rd_en pulse in cycle T, the FIFO byte is latched at T+1 and the start bit drives cycles T+2 .. T+1+CLKS_PER_BIT.
- Frame length: 10*CLKS_PER_BIT cycles (11* with parity).
- Back-to-back bytes: the last stop cycle is followed by one IDLE cycle (rd_en) and one FETCH cycle, both with tx=1. Period = 2 + 10*CLKS_PER_BIT cycles.
- tx_busy rises in the rd_en cycle and falls in the cycle after the last stop-bit cycle.

## Configuration
- FIFO_UART_TX_PARITY_EN defined:
  - A PARITY state is inserted between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - tx = XOR of the 8 data bits (even parity).
- Undefined: no parity state; the frame is 8N1.

## Test plan
- Reset: assert rst for 2 cycles with FIFO non-empty -> tx=1, rd_en=0, tx_busy=0, frame_count=0 throughout.
- Single byte 8'hA5, CLKS_PER_BIT=4:
  - Exactly one rd_en pulse.
  - tx sequence, 4 cycles per level: 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop).
  - frame_count becomes 1 after 42 cycles from rd_en.
- Three queued bytes 8'h01, 8'h80, 8'hFF:
  - rd_en pulses exactly 42 cycles apart.
  - Decoded bytes match, in order.
  - frame_count=3; tx_busy low after the third stop bit.
- tx_enable=0 with 5 bytes in the FIFO:
  - No rd_en for 200 cycles.
  - Raise tx_enable, then drop it during the first data bit -> exactly one frame is sent, then idle.
- Reset mid-frame during data bit 3 of 8'h3C:
  - tx=1 immediately; shift register is cleared.
  - After release, the next FIFO byte is sent complete and frame_count=1.
- With FIFO_UART_TX_PARITY_EN, byte 8'h07:
  - Parity bit is 1; 8'h03 gives parity bit 0.
  - Frame period is 2+11*CLKS_PER_BIT cycles.
